// File: rtl/int_ctrl_n.sv
// Vectored, nestable interrupt controller for a 5-stage RISC core.
// Edge-captured requests, fixed priority (line 0 highest), EPC stack.
module int_ctrl_n #(
  parameter int unsigned N_IRQ      = 3,
  parameter int unsigned NEST_DEPTH = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                              clk,
  input  logic                              CLR,
  input  logic                              EN,
  input  logic [N_IRQ-1:0]                  irq,
  input  logic                              ex_valid,
  input  logic [31:0]                       pc_ex,
  input  logic                              branch_taken,
  input  logic [31:0]                       pc_branch,
  input  logic                              jump_ex,
  input  logic                              eret,
  input  logic                              mask_we,
  input  logic [N_IRQ-1:0]                  mask_din,
  output logic                              int_take,
  output logic [31:0]                       int_vec,
  output logic [31:0]                       epc,
  output logic [N_IRQ-1:0]                  pending,
  output logic [N_IRQ-1:0]                  in_service,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(NEST_DEPTH + 1);
  localparam int unsigned IW = $clog2(N_IRQ + 1);
  localparam logic [DW-1:0] DMAX = DW'(NEST_DEPTH);

  logic [N_IRQ-1:0] irq_q, irq_edge;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] insvc_q, insvc_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [31:0]      stack_q [NEST_DEPTH];
  logic [31:0]      stack_d [NEST_DEPTH];

  logic          cand_vld;
  logic [IW-1:0] cand_idx;
  logic [IW-1:0] cur_lvl;
  logic          push;
  logic          pop;
  logic [31:0]   ret_addr;

  assign irq_edge = irq & ~irq_q;

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    cur_lvl  = IW'(N_IRQ);
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i] & mask_q[i]) begin
        cand_vld = 1'b1;
        cand_idx = IW'(i);
      end
      if (insvc_q[i]) begin
        cur_lvl = IW'(i);
      end
    end
  end

  assign push = !CLR & EN & ex_valid & !jump_ex & !eret
              & cand_vld & (cand_idx < cur_lvl)
              & (depth_q < DMAX);
  assign pop  = EN & eret & (depth_q != '0);

  assign int_take = push;
  assign int_vec  = VEC_BASE + 32'(cand_idx) * VEC_STRIDE;
  assign ret_addr = branch_taken ? pc_branch : pc_ex + 32'd4;

  always_comb begin
    pending_d = pending_q;
    insvc_d   = insvc_q;
    mask_d    = mask_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (push && cand_idx == IW'(i)) begin
        pending_d[i] = 1'b0;
        insvc_d[i]   = 1'b1;
      end
      if (pop && cur_lvl == IW'(i)) begin
        insvc_d[i] = 1'b0;
      end
    end
    // A fresh edge is never lost, even on the line being taken.
    pending_d = pending_d | irq_edge;
    for (int j = 0; j < NEST_DEPTH; j++) begin
      if (push && depth_q == DW'(j)) begin
        stack_d[j] = ret_addr;
      end
    end
    if (push) begin
      depth_d = depth_q + DW'(1);
    end else if (pop) begin
      depth_d = depth_q - DW'(1);
    end
    if (EN && mask_we) begin
      mask_d = mask_din;
    end
  end

  always_comb begin
    epc = '0;
    for (int j = 0; j < NEST_DEPTH; j++) begin
      if (depth_q == DW'(j + 1)) begin
        epc = stack_q[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      irq_q     <= '0;
      pending_q <= '0;
      insvc_q   <= '0;
      mask_q    <= '1;
      depth_q   <= '0;
      for (int j = 0; j < NEST_DEPTH; j++) begin
        stack_q[j] <= '0;
      end
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      insvc_q   <= insvc_d;
      mask_q    <= mask_d;
      depth_q   <= depth_d;
      stack_q   <= stack_d;
    end
  end

  assign pending    = pending_q;
  assign in_service = insvc_q;
  assign depth      = depth_q;

endmodule
